// File: rtl/alu_sequencer.sv
// ALU bus sequencer: arbitrates two requesters and issues LATCHOP / WRITEC / [WRITEF] commands.
// Define ALU_SEQ_RR_EN for round-robin arbitration; the default build is fixed priority (req 0).
package alu_seq_pkg;
  typedef enum logic [1:0] {
    COM_NONE    = 2'd0,
    COM_LATCHOP = 2'd1,
    COM_WRITEC  = 2'd2,
    COM_WRITEF  = 2'd3
  } command_t;
endpackage

module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned WORDSIZE = 16,
  parameter int unsigned OPW      = 4
) (
  input  logic                i_Clk,
  input  logic                i_Reset_n,
  input  logic [1:0]          i_req,
  input  logic [OPW-1:0]      i_op0,
  input  logic [OPW-1:0]      i_op1,
  input  logic [1:0]          i_wflags,
  output logic [1:0]          o_grant,
  output logic [1:0]          o_done,
  output logic                o_busy,
  output logic                o_bus_valid,
  output command_t            o_bus_command,
  output logic [WORDSIZE-1:0] o_bus_data
);

  typedef enum logic [2:0] {StIdle, StLatchOp, StWriteC, StWriteF, StDone} state_t;

  state_t         state_q;
  logic           wflags_q;
  logic           win;
  logic [1:0]     win_grant;
  logic [OPW-1:0] win_op;
  logic           win_wflags;

`ifdef ALU_SEQ_RR_EN
  logic rr_q;
  assign win = (i_req == 2'b11) ? rr_q : i_req[1];
`else
  assign win = i_req[1] & ~i_req[0];
`endif

  assign win_grant  = win ? 2'b10 : 2'b01;
  assign win_op     = win ? i_op1 : i_op0;
  assign win_wflags = win ? i_wflags[1] : i_wflags[0];

  // Outputs are registered alongside the state; the opcode is captured straight into the
  // LATCHOP data register and the owner lives in o_grant.
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q       <= StIdle;
      wflags_q      <= 1'b0;
`ifdef ALU_SEQ_RR_EN
      rr_q          <= 1'b0;
`endif
      o_grant       <= '0;
      o_done        <= '0;
      o_busy        <= 1'b0;
      o_bus_valid   <= 1'b0;
      o_bus_command <= COM_NONE;
      o_bus_data    <= '0;
    end else begin
      o_done <= '0;
      unique case (state_q)
        StIdle: begin
          if (|i_req) begin
            state_q       <= StLatchOp;
            wflags_q      <= win_wflags;
`ifdef ALU_SEQ_RR_EN
            rr_q          <= ~win;
`endif
            o_grant       <= win_grant;
            o_busy        <= 1'b1;
            o_bus_valid   <= 1'b1;
            o_bus_command <= COM_LATCHOP;
            o_bus_data    <= WORDSIZE'(win_op);
          end
        end
        StLatchOp: begin
          state_q       <= StWriteC;
          o_bus_command <= COM_WRITEC;
          o_bus_data    <= '0;
        end
        StWriteC: begin
          if (wflags_q) begin
            state_q       <= StWriteF;
            o_bus_command <= COM_WRITEF;
          end else begin
            state_q       <= StDone;
            o_bus_valid   <= 1'b0;
            o_bus_command <= COM_NONE;
            o_done        <= o_grant;
          end
        end
        StWriteF: begin
          state_q       <= StDone;
          o_bus_valid   <= 1'b0;
          o_bus_command <= COM_NONE;
          o_done        <= o_grant;
        end
        StDone: begin
          // Leaving DONE always passes through IDLE, so held requests wait one cycle.
          state_q <= StIdle;
          o_grant <= '0;
          o_busy  <= 1'b0;
        end
        default: begin
          state_q       <= StIdle;
          o_grant       <= '0;
          o_busy        <= 1'b0;
          o_bus_valid   <= 1'b0;
          o_bus_command <= COM_NONE;
          o_bus_data    <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have parameter WORDSIZE, default 16, bus data width.
REQ-002 SHALL have parameter OPW, default 4, ALU opcode width.
REQ-003 SHALL have port i_Clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port i_Reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_req  input  2  per-requester operation request, held until o_done.
REQ-006 SHALL have port i_op0  input  OPW  requester 0 ALU opcode.
REQ-007 SHALL have port i_op1  input  OPW  requester 1 ALU opcode.
REQ-008 SHALL have port i_wflags  input  2  per-requester flag write-back enable.
REQ-009 SHALL have port o_grant  output  2  one-hot owner of current sequence.
REQ-010 SHALL have port o_done  output  2  one-cycle completion pulse to owner.
REQ-011 SHALL have port o_busy  output  1  high in any state other than IDLE.
REQ-012 SHALL have port o_bus_valid  output  1  bus command valid.
REQ-013 SHALL have port o_bus_command  output  command_t  ALU bus command.
REQ-014 SHALL have port o_bus_data  output  WORDSIZE  ALU bus data.

Function
REQ-015 SHALL implement FSM states IDLE, LATCHOP, WRITEC, WRITEF, DONE.
REQ-016 IDLE: any i_req bit high at an edge -> select winner, capture its opcode and i_wflags bit, go to LATCHOP; else stay.
REQ-017 LATCHOP: o_bus_valid=1, o_bus_command=COM_LATCHOP, o_bus_data={zeros, captured opcode}; next WRITEC.
REQ-018 WRITEC: o_bus_valid=1, o_bus_command=COM_WRITEC, o_bus_data=0; next WRITEF if captured wflags=1, else DONE.
REQ-019 WRITEF: o_bus_valid=1, o_bus_command=COM_WRITEF, o_bus_data=0; next DONE.
REQ-020 DONE: o_done[owner]=1 for exactly this cycle; next IDLE.
REQ-021 In IDLE and DONE: o_bus_valid=0, o_bus_command='0, o_bus_data='0 (no spurious register-file write).
REQ-022 o_grant[owner]=1 from LATCHOP through DONE inclusive; o_grant=0 in IDLE.
REQ-023 Latency: request sampled at edge N -> LATCHOP cycle N+1, WRITEC N+2, WRITEF N+3 (if flags), DONE N+3 or N+4.
REQ-024 Opcode and wflags SHALL be captured once in IDLE; changes to i_op*/i_wflags during a sequence SHALL be ignored.
REQ-025 Owner deasserting i_req mid-sequence SHALL NOT abort; sequence completes, o_done still pulses.
REQ-026 A request still high in DONE SHALL NOT be granted until the following IDLE cycle (minimum one IDLE cycle between sequences).
REQ-027 Both i_req high in IDLE: winner chosen per REQ-033/REQ-034; loser waits, no request lost.
REQ-028 Outputs SHALL be registered-state decodes only; no combinational path from i_req to o_bus_*.

Reset
REQ-029 i_Reset_n low SHALL immediately force state IDLE, regardless of clock.
REQ-030 During reset: o_grant=0, o_done=0, o_busy=0, o_bus_valid=0, o_bus_command='0, o_bus_data='0.
REQ-031 Reset SHALL clear captured opcode, captured wflags, and round-robin pointer (pointer=requester 0 preferred).
REQ-032 Reset mid-sequence SHALL abandon the sequence with no o_done pulse; requests resample on first edge after release.

Configuration
REQ-033 With macro ALU_SEQ_RR_EN defined: round-robin; pointer names preferred requester, updates to non-winner on each grant.
REQ-034 Without ALU_SEQ_RR_EN: fixed priority, requester 0 always wins ties; no pointer state.

Verification
REQ-035 Req0 only, op=ALU_ADD (0), wflags=1 -> LATCHOP data=0x0000, WRITEC, WRITEF, o_done=2'b01 four cycles after sampling edge.
REQ-036 Req1 only, op=0xF, wflags=0 -> LATCHOP data=0x000F, WRITEC, DONE; no WRITEF cycle; o_done=2'b10 three cycles after sampling edge.
REQ-037 Both req held continuously, RR_EN defined -> grants alternate 01,10,01,10; undefined -> grants 01 every sequence.
REQ-038 Owner changes i_op0 0x3->0x9 and drops i_req during WRITEC -> sequence completes with latched op 0x3, o_done pulses.
REQ-039 i_Reset_n low asynchronously in WRITEC -> all outputs 0 before next edge, no o_done; after release, held request starts fresh LATCHOP.
